// File: rtl/bp_pkg.sv
// Shared constants and saturating-counter helpers for the branch predictor.
// Counters are carried at a fixed 4-bit width; callers pass the live width.
package bp_pkg;

    localparam logic [1:0] BP_STATIC_NT = 2'd0;
    localparam logic [1:0] BP_BIMODAL   = 2'd1;
    localparam logic [1:0] BP_GSHARE    = 2'd2;

    localparam int unsigned CTR_MAX_BITS = 32'd4;

    typedef logic [CTR_MAX_BITS-1:0] ctr_t;

    function automatic ctr_t ctr_max(input int unsigned width);
        return ctr_t'((32'd1 << width) - 32'd1);
    endfunction

    function automatic ctr_t sat_inc(input ctr_t value, input int unsigned width);
        ctr_t top_s;
        top_s = ctr_max(width);
        if (value >= top_s) begin
            return top_s;
        end else begin
            return value + 4'd1;
        end
    endfunction

    function automatic ctr_t sat_dec(input ctr_t value, input int unsigned width);
        if ((value == 4'd0) || (width == 32'd0)) begin
            return 4'd0;
        end else begin
            return value - 4'd1;
        end
    endfunction

    // Weakly not-taken: one below the taken threshold, or zero for 1-bit counters.
    function automatic ctr_t weak_nt(input int unsigned width);
        if (width <= 32'd1) begin
            return 4'd0;
        end else begin
            return ctr_t'((32'd1 << (width - 32'd1)) - 32'd1);
        end
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational read, registered write.
// Addresses arrive word-aligned (pc[31:2]); clear drops only the valid bits.
module bp_btb #(
    parameter int unsigned ENTRIES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [29:0] rd_addr,
    output logic        rd_hit,
    output logic [31:0] rd_target,
    output logic        rd_is_cond,
    input  logic        wr_en,
    input  logic [29:0] wr_addr,
    input  logic [31:0] wr_target,
    input  logic        wr_is_cond
);

    localparam int unsigned IB    = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32'd30 - IB;

    logic [ENTRIES-1:0] valid_r;
    logic [ENTRIES-1:0] is_cond_r;
    logic [TAG_W-1:0]   tag_r    [ENTRIES];
    logic [31:0]        target_r [ENTRIES];

    logic [IB-1:0]    rd_idx_s;
    logic [TAG_W-1:0] rd_tag_s;
    logic [IB-1:0]    wr_idx_s;
    logic [TAG_W-1:0] wr_tag_s;

    assign rd_idx_s = rd_addr[IB-1:0];
    assign rd_tag_s = rd_addr[29:IB];
    assign wr_idx_s = wr_addr[IB-1:0];
    assign wr_tag_s = wr_addr[29:IB];

    // Read port: hit needs a valid entry whose stored tag matches.
    always_comb begin
        rd_hit     = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s);
        rd_target  = target_r[rd_idx_s];
        rd_is_cond = is_cond_r[rd_idx_s];
    end

    // Write port: an aliasing entry is simply overwritten.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r   <= {ENTRIES{1'b0}};
            is_cond_r <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= 32'h0000_0000;
            end
        end else if (clear) begin
            valid_r <= {ENTRIES{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx_s]   <= 1'b1;
            is_cond_r[wr_idx_s] <= wr_is_cond;
            tag_r[wr_idx_s]     <= wr_tag_s;
            target_r[wr_idx_s]  <= wr_target;
        end
    end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Same-cycle next-PC predictor: BTB plus a PHT of saturating counters indexed
// bimodally or gshare-style, trained by resolved branches; keeps statistics.
module gshare_btb_predictor
    import bp_pkg::*;
#(
    parameter logic [1:0]  MODE        = 2'd2,
    parameter int unsigned BTB_ENTRIES = 32,
    parameter int unsigned GHR_BITS    = 5,
    parameter int unsigned CTR_BITS    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                lookup_valid,
    input  logic [31:0]         pc,
    output logic                pred_taken,
    output logic                btb_hit,
    output logic [31:0]         pred_next_pc,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                upd_is_cond,
    input  logic                upd_taken,
    input  logic [31:0]         upd_target,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_mispredict,
    output logic [31:0]         stat_lookups,
    output logic [31:0]         stat_mispredicts
);

    localparam int unsigned         PHT_N    = 32'd1 << GHR_BITS;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(weak_nt(CTR_BITS));

    logic [CTR_BITS-1:0] pht_r [PHT_N];
    logic [GHR_BITS-1:0] ghr_r;
    logic [31:0]         stat_lookups_r;
    logic [31:0]         stat_mispredicts_r;

    logic [GHR_BITS-1:0] rd_idx_s;
    logic [GHR_BITS-1:0] wr_idx_s;
    logic [GHR_BITS-1:0] ghr_next_s;
    logic [CTR_BITS-1:0] rd_ctr_s;
    logic [CTR_BITS-1:0] wr_ctr_s;
    logic [CTR_BITS-1:0] ctr_next_s;
    logic                btb_hit_s;
    logic [31:0]         btb_target_s;
    logic                btb_is_cond_s;
    logic                pred_taken_s;
    logic                btb_wr_en_s;
    logic                pht_wr_en_s;
    logic                unused_upd_bits_s;

    assign unused_upd_bits_s = ^upd_pc[1:0];

    bp_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .rd_addr    (pc[31:2]),
        .rd_hit     (btb_hit_s),
        .rd_target  (btb_target_s),
        .rd_is_cond (btb_is_cond_s),
        .wr_en      (btb_wr_en_s),
        .wr_addr    (upd_pc[31:2]),
        .wr_target  (upd_target),
        .wr_is_cond (upd_is_cond)
    );

    // PHT indexing for both ports; gshare folds the relevant history in.
    always_comb begin
        rd_idx_s = pc[GHR_BITS+1:2];
        wr_idx_s = upd_pc[GHR_BITS+1:2];
        if (MODE == BP_GSHARE) begin
            rd_idx_s = pc[GHR_BITS+1:2] ^ ghr_r;
            wr_idx_s = upd_pc[GHR_BITS+1:2] ^ upd_ghr;
        end else begin
            rd_idx_s = pc[GHR_BITS+1:2];
            wr_idx_s = upd_pc[GHR_BITS+1:2];
        end
    end

    if (GHR_BITS == 1) begin : g_ghr_single
        assign ghr_next_s = upd_taken;
    end else begin : g_ghr_shift
        assign ghr_next_s = {ghr_r[GHR_BITS-2:0], upd_taken};
    end

    assign rd_ctr_s    = pht_r[rd_idx_s];
    assign wr_ctr_s    = pht_r[wr_idx_s];
    assign btb_wr_en_s = upd_valid && !clear;
    assign pht_wr_en_s = upd_valid && upd_is_cond && !clear;

    // Counter training value; widened to the helper width and narrowed back.
    always_comb begin
        ctr_next_s = wr_ctr_s;
        if (upd_taken) begin
            ctr_next_s = CTR_BITS'(sat_inc(ctr_t'(wr_ctr_s), CTR_BITS));
        end else begin
            ctr_next_s = CTR_BITS'(sat_dec(ctr_t'(wr_ctr_s), CTR_BITS));
        end
    end

    // Direction decision: unconditional hits are always taken.
    always_comb begin
        pred_taken_s = 1'b0;
        if (MODE == BP_STATIC_NT) begin
            pred_taken_s = 1'b0;
        end else begin
            pred_taken_s = btb_hit_s && (!btb_is_cond_s || rd_ctr_s[CTR_BITS-1]);
        end
    end

    assign pred_taken       = pred_taken_s;
    assign btb_hit          = btb_hit_s;
    assign pred_next_pc     = pred_taken_s ? btb_target_s : (pc + 32'd4);
    assign pred_ghr         = ghr_r;
    assign stat_lookups     = stat_lookups_r;
    assign stat_mispredicts = stat_mispredicts_r;

    // Pattern history table storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht_r[i] <= CTR_INIT;
            end
        end else if (clear) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht_r[i] <= CTR_INIT;
            end
        end else if (pht_wr_en_s) begin
            pht_r[wr_idx_s] <= ctr_next_s;
        end
    end

    // Global history only moves on conditional outcomes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_r <= {GHR_BITS{1'b0}};
        end else if (clear) begin
            ghr_r <= {GHR_BITS{1'b0}};
        end else if (pht_wr_en_s) begin
            ghr_r <= ghr_next_s;
        end
    end

    // Saturating statistics; clear leaves them intact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_lookups_r     <= 32'h0000_0000;
            stat_mispredicts_r <= 32'h0000_0000;
        end else begin
            if (lookup_valid && (stat_lookups_r != 32'hFFFF_FFFF)) begin
                stat_lookups_r <= stat_lookups_r + 32'd1;
            end
            if (upd_valid && upd_mispredict && (stat_mispredicts_r != 32'hFFFF_FFFF)) begin
                stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
            end
        end
    end

endmodule
